// File: rtl/fetch_pkg.sv
// Shared types and sizing helpers for the instruction fetch front end.
package fetch_pkg;

  localparam int FETCH_INST_W    = 16;
  localparam int FETCH_ADDR_W    = 12;
  localparam int FETCH_BUF_DEPTH = 2;

  // Counter wide enough to hold 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int CNT_W = $clog2(FETCH_BUF_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } fetch_state_e;

  typedef struct packed {
    logic [FETCH_INST_W-1:0] instruction;
    logic [FETCH_ADDR_W-1:0] addr;
  } fetch_entry_t;

endpackage

// File: rtl/instruction_buffer.sv
// Small synchronous FIFO of fetched {instruction, addr} entries.
// Clear overrides push and pop; a pop frees room for a same-cycle push when full.
module instruction_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_BUF_DEPTH,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  fetch_entry_t  push_entry,
  input  logic          pop,
  input  logic          clear,
  output fetch_entry_t  head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign count   = count_reg;
  assign do_pop  = pop && !empty && !clear;
  assign do_push = push && !clear && (!full || do_pop);

  // Empty entries read as zero so the decoder never sees stale storage.
  assign head = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      unique case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: credit-limited word requests to instruction memory, in-order
// response buffering, and redirect handling that drops stale in-flight data.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int                  INST_W       = FETCH_INST_W,
  parameter int                  I_ADDR_W     = FETCH_ADDR_W,
  parameter int                  BUF_DEPTH    = FETCH_BUF_DEPTH,
  parameter logic [I_ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                redirect_valid,
  input  logic [I_ADDR_W-1:0] redirect_addr,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [I_ADDR_W-1:0] imem_req_addr,
  input  logic                imem_rsp_valid,
  input  logic [INST_W-1:0]   imem_rsp_data,
  output logic                instruction_valid,
  input  logic                instruction_ready,
  output logic [INST_W-1:0]   instruction,
  output logic [I_ADDR_W-1:0] instruction_addr,
  output logic                fetch_error
);

  localparam int CW = cnt_width(BUF_DEPTH);

  fetch_state_e        state_reg, state_next;
  logic [I_ADDR_W-1:0] fetch_ptr_reg, fetch_ptr_next;
  logic [I_ADDR_W-1:0] rsp_ptr_reg, rsp_ptr_next;
  logic [CW-1:0]       outstanding_reg, outstanding_next;
  logic [CW-1:0]       discard_reg, discard_next;
  logic                fetch_error_reg, fetch_error_next;
  logic [CW-1:0]       occupancy;
  logic [CW:0]         credit_used;
  logic                req_fire;
  logic                buf_push, buf_pop, buf_full, buf_empty;
  fetch_entry_t        push_entry, head_entry;

  // Every request holds a credit until its instruction leaves the buffer.
  assign credit_used    = {1'b0, outstanding_reg} + {1'b0, occupancy};
  assign imem_req_valid = (state_reg == RUN) && enable && !redirect_valid &&
                          (credit_used < (CW+1)'(BUF_DEPTH));
  assign imem_req_addr  = fetch_ptr_reg;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign push_entry        = '{instruction: imem_rsp_data, addr: rsp_ptr_reg};
  assign instruction_valid = !buf_empty;
  assign instruction       = head_entry.instruction;
  assign instruction_addr  = head_entry.addr;
  assign fetch_error       = fetch_error_reg;

  always_comb begin
    state_next       = state_reg;
    fetch_ptr_next   = fetch_ptr_reg;
    rsp_ptr_next     = rsp_ptr_reg;
    outstanding_next = outstanding_reg;
    discard_next     = discard_reg;
    fetch_error_next = fetch_error_reg;
    buf_push         = 1'b0;
    buf_pop          = 1'b0;

    if (redirect_valid) begin
      fetch_ptr_next   = redirect_addr;
      rsp_ptr_next     = redirect_addr;
      outstanding_next = '0;
      if (imem_rsp_valid && discard_reg == '0 && outstanding_reg == '0) begin
        fetch_error_next = 1'b1;
        discard_next     = '0;
      end else begin
        discard_next = discard_reg + outstanding_reg - CW'(imem_rsp_valid);
      end
    end else begin
      buf_pop = instruction_valid && instruction_ready;
      if (req_fire) begin
        fetch_ptr_next   = fetch_ptr_reg + I_ADDR_W'(1);
        outstanding_next = outstanding_reg + CW'(1);
      end
      if (imem_rsp_valid) begin
        if (discard_reg != '0) begin
          discard_next = discard_reg - CW'(1);
        end else if (outstanding_reg != '0 && !(buf_full && !buf_pop)) begin
          buf_push         = 1'b1;
          rsp_ptr_next     = rsp_ptr_reg + I_ADDR_W'(1);
          outstanding_next = outstanding_next - CW'(1);
        end else begin
          fetch_error_next = 1'b1;
        end
      end
    end

    unique case (state_reg)
      IDLE:    state_next = RUN;
      RUN:     if (redirect_valid && discard_next != '0) state_next = FLUSH;
      FLUSH:   if (discard_next == '0) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      fetch_ptr_reg   <= RESET_VECTOR;
      rsp_ptr_reg     <= RESET_VECTOR;
      outstanding_reg <= '0;
      discard_reg     <= '0;
      fetch_error_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      fetch_ptr_reg   <= fetch_ptr_next;
      rsp_ptr_reg     <= rsp_ptr_next;
      outstanding_reg <= outstanding_next;
      discard_reg     <= discard_next;
      fetch_error_reg <= fetch_error_next;
    end
  end

  instruction_buffer #(
    .DEPTH (BUF_DEPTH),
    .CW    (CW)
  ) u_buffer (
    .clk        (clk),
    .reset      (reset),
    .push       (buf_push),
    .push_entry (push_entry),
    .pop        (buf_pop),
    .clear      (redirect_valid),
    .head       (head_entry),
    .full       (buf_full),
    .empty      (buf_empty),
    .count      (occupancy)
  );

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Front-end stage directly upstream of the instruction decoder. Issues word-address requests to instruction memory over a valid/ready request channel and collects in-order responses.
- Buffers up to BUF_DEPTH fetched instructions and presents the head instruction, with its address, to the decoder under a valid/ready handshake.
- Redirects on jumps and branches taken, flushing buffered instructions and discarding stale in-flight responses.

Parameters:
- INST_W, 16, instruction width.
- I_ADDR_W, 12, instruction word-address width.
- BUF_DEPTH, 2, buffer entries; also the maximum number of outstanding requests plus buffered instructions. Must be ≥1.
- RESET_VECTOR, 0, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  permits new memory requests; in-flight responses still complete.
- redirect_valid  in  1  jump or branch taken; one-cycle pulse from the program counter.
- redirect_addr  in  I_ADDR_W  new fetch address.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  I_ADDR_W  request word address.
- imem_rsp_valid  in  1  response valid. Responses are in order; latency is ≥1 cycle after acceptance.
- imem_rsp_data  in  INST_W  response instruction.
- instruction_valid  out  1  head instruction available.
- instruction_ready  in  1  decoder or core consumes the head instruction.
- instruction  out  INST_W  head instruction; feeds the decoder instruction input.
- instruction_addr  out  I_ADDR_W  address of the head instruction, used for PC-relative targets.
- fetch_error  out  1  sticky flag: unexpected response received.

Behaviour:
- Reset values:
  - state IDLE
  - fetch_ptr = rsp_ptr = RESET_VECTOR
  - buffer empty; outstanding = 0; discard = 0
  - imem_req_valid = 0, instruction_valid = 0, instruction = 0, instruction_addr = 0, fetch_error = 0
- Reset has priority over every other input. Reset asserted mid-operation abandons all state. Responses arriving after reset for pre-reset requests count as unexpected.
- States: IDLE, RUN, FLUSH.
  - IDLE → RUN on the first cycle after reset deassertion.
  - RUN → FLUSH on redirect when discard_next > 0.
  - FLUSH → RUN when discard reaches 0.
- Request issue:
  - imem_req_valid = (state == RUN) && enable && !redirect_valid && (outstanding + occupancy < BUF_DEPTH). Combinational from registered state and these inputs.
  - imem_req_addr = fetch_ptr.
  - On accept (valid && ready): fetch_ptr increments by 1, wrapping modulo 2^I_ADDR_W; outstanding increments.
  - While valid && !ready, the request address stays stable unless a redirect occurs.
- Responses:
  - If discard > 0: the response is dropped and discard decrements.
  - Else if outstanding > 0: push {rsp_data, rsp_ptr} into the buffer, increment rsp_ptr (wrapping), decrement outstanding. The credit rule guarantees no overflow.
  - Else: the response is ignored and fetch_error is set; it stays set until reset.
- Output:
  - instruction_valid = buffer not empty.
  - instruction and instruction_addr come from the head entry and are registered (no memory-to-output bypass).
  - Pop on instruction_valid && instruction_ready.
  - A response pushed in cycle N is visible in cycle N+1. Simultaneous push and pop on a full buffer is legal.
- Redirect (highest priority after reset):
  - fetch_ptr ← redirect_addr and rsp_ptr ← redirect_addr.
  - Buffer is cleared; a same-cycle pop is ignored.
  - A same-cycle response is discarded.
  - discard_next = discard + outstanding − (imem_rsp_valid ? 1 : 0); outstanding ← 0.
  - No request is accepted in the redirect cycle.
  - A redirect during FLUSH updates the pointers and accumulates discard the same way.
- Minimum redirect-to-instruction latency with an idle pipe and 1-cycle memory:
  - redirect at N
  - request at N+1
  - response at N+2
  - instruction_valid at N+3
- enable low: no new requests. Outstanding responses are still buffered and the buffer still drains.

Decomposition:
- fetch_pkg holds:
  - fetch_state_e {IDLE, RUN, FLUSH}
  - fetch_entry_t struct {instruction, addr}
  - localparam counter width $clog2(BUF_DEPTH+1)
- Sub-module instruction_buffer: synchronous FIFO of fetch_entry_t with push, pop, clear, full, empty, and occupancy count. Pop has priority on equal-cycle push when full. Clear overrides push and pop.

Test Plan:
- Reset then enable, memory always ready, 1-cycle latency, instruction_ready = 1 → requests to 0,1,2,…; instruction_addr 0 at cycle 3, then one instruction per cycle; instruction equals the memory contents at each address.
- instruction_ready = 0 with BUF_DEPTH = 2 → exactly 2 requests accepted, then imem_req_valid = 0; instruction holds the entry for addr 0. Raising ready resumes the stream from addr 2.
- 3-cycle memory latency, redirect_addr = 0x100 with 2 requests outstanding → both stale responses dropped, FLUSH held for those cycles; first delivered instruction_addr = 0x100.
- Redirect in the same cycle as a response and a pop → buffer empty the next cycle, discard = outstanding − 1, no stale instruction ever presented.
- fetch_ptr = 0xFFF → next request address is 0x000; instruction_addr sequence reads 0xFFF, 0x000.
- Spurious imem_rsp_valid with nothing outstanding → fetch_error = 1, buffer unchanged; fetch_error cleared only by reset.
